onchip_mem_arbiter: RTL and testbench
=====================================

# onchip_mem_arbiter

Two-port Avalon-MM arbiter that shares the single-port 1024×32 on-chip RAM between the HPS lightweight-bridge master (port 0) and the FPGA cube-state engine (port 1). Issues at most one RAM access per cycle and arbitrates round-robin. Supports an optional lock for atomic read-modify-write sequences. Returns read data with fixed one-cycle latency through `readdatavalid`. Sits between the interconnect masters and the RAM's `s1` slave.

## Interface

- `ADDR_W`, 10, word address width (1024 words)
- `DATA_W`, 32, data width
- `BE_W`, 4, byteenable width (`DATA_W/8`)
- `LOCK_TIMEOUT`, 16, idle cycles after which a held lock is forcibly released (≥1)
- `clk`  in  1  single clock for arbiter and RAM
- `reset_n`  in  1  asynchronous, active-low reset
- `mN_address`  in  ADDR_W  requester N word address (N = 0, 1)
- `mN_byteenable`  in  BE_W  requester N byte lanes
- `mN_read` / `mN_write`  in  1  requester N read / write request; never both high together
- `mN_writedata`  in  DATA_W  requester N write data
- `mN_lock`  in  1  hold the grant after this transfer
- `mN_waitrequest`  out  1  low = requester N's transfer accepted this cycle
- `mN_readdata`  out  DATA_W  read data, valid with `mN_readdatavalid`
- `mN_readdatavalid`  out  1  one-cycle read-response strobe
- `mem_address` / `mem_byteenable` / `mem_writedata`  out  ADDR_W / BE_W / DATA_W  to RAM
- `mem_chipselect`, `mem_write`  out  1  RAM strobes
- `mem_clken`  out  1  RAM clock enable; tied 1
- `mem_readdata`  in  DATA_W  RAM q; valid the cycle after the read address is presented

## Operation

- `reqN = mN_read | mN_write`.
- Grant decision is combinational from `reqN`, arbiter state and the round-robin pointer `rr_last` (last requester served).
- Transfer state machine (`arb_state`):
  - **OPEN**, reset state:
    - If both requesters request, grant the one not equal to `rr_last`; if only one requests, grant it.
    - A granted transfer with `mN_lock=1` moves the FSM to **LOCKN**.
  - **LOCK0 / LOCK1**:
    - Only the lock owner can be granted; the other requester's `waitrequest` stays 1.
    - A granted owner transfer with `lock=0` returns the FSM to **OPEN**.
    - Each owner-idle cycle increments `idle_cnt`, and any owner transfer clears it.
    - When `idle_cnt` reaches `LOCK_TIMEOUT-1`, the FSM returns to **OPEN** on the next edge.
- Granted port:
  - Its `waitrequest` is 0 and its command fields are muxed onto `mem_*`.
  - `mem_chipselect` = 1 and `mem_write` = `mN_write`.
  - `rr_last` ← N.
- Ungranted ports: `waitrequest` = 1, including when idle.
- With no grant, `mem_chipselect` = 0 and `mem_write` = 0; `mem_address` is don't-care but is held at its last value.
- Read pipeline:
  - A granted read sets `rd_pend` = 1 and `rd_owner` = N at the clock edge.
  - On the following cycle, `mN_readdatavalid` = `rd_pend & (rd_owner == N)` and `mN_readdata` = `mem_readdata`. Both `readdata` outputs are driven from `mem_readdata`.
- Writes have no response phase.
- Reset, asynchronous: `arb_state` = OPEN, `rr_last` = 1 (port 0 wins first tie), `idle_cnt` = 0, `rd_pend` = 0.
- Output values during reset:
  - `waitrequest` outputs: 1
  - `readdatavalid` outputs: 0
  - `mem_chipselect`, `mem_write`: 0
  - `mem_clken`: 1
- An in-flight read response is discarded if reset is asserted mid-operation.

## Timing

- Accept latency: 0 cycles. A request is accepted in the cycle it is presented if it is granted.
- Read latency: `readdatavalid` exactly 1 cycle after acceptance.
- Throughput: one access per cycle with no bubbles between requesters, so read-to-read, read-to-write and write-to-read can run back to back.
- Read-during-write to the same address on consecutive cycles: the RAM is DONT_CARE on the same cycle only. The write is complete before the next cycle's read, so the next-cycle read returns the new data.
- Fairness: with both requesters continuously requesting and no lock, grants alternate 0,1,0,1…
- Lock: the maximum starvation of the other port is bounded by lock-owner activity plus `LOCK_TIMEOUT` idle cycles.

## Structure

- Package `onchip_arb_pkg`:
  - `arb_state_t` enum {OPEN, LOCK0, LOCK1}
  - default widths `ADDR_W`, `DATA_W`, `BE_W`
  - `LOCK_TIMEOUT` default
- Sub-module `rr_grant2`: purely combinational 2-way round-robin grant from `req[1:0]`, `rr_last`, and a `mask[1:0]` input driven by the lock state.
- The top module holds the FSM, `idle_cnt`, the `rr_last` and `rd_pend`/`rd_owner` registers, and the command mux.

## Test plan

- **Reset:** hold `reset_n`=0 with both ports requesting → both `waitrequest`=1, `mem_chipselect`=0, `readdatavalid`=0. On release, port 0 is granted first.
- **Single read:** port 0 writes 0xDEADBEEF to address 0x005 with byteenable 0xF, then reads 0x005 → read accepted with `waitrequest`=0 in the same cycle; `m0_readdatavalid` and `m0_readdata`=0xDEADBEEF one cycle later.
- **Contention:** both ports issue 4 back-to-back reads to 0x010–0x013 → grants alternate 0,1,0,1; each port gets 4 `readdatavalid` strobes, each 1 cycle after its acceptance; no idle `mem` cycles.
- **Byte lanes:** write 0x11223344 to 0x3FF (wrap-top address), then write 0xAA000000 with byteenable 0x8, then read → 0xAA223344.
- **Lock RMW:** port 1 reads 0x020 with `lock`=1 while port 0 requests continuously, then port 1 writes with `lock`=0 → port 0 `waitrequest`=1 throughout, and port 0 is granted the cycle after the unlocking write.
- **Lock timeout:** port 1 locks and then goes idle while port 0 requests → port 0 is granted exactly `LOCK_TIMEOUT`+1 cycles after port 1's last transfer. Asserting reset mid-read drops the pending `readdatavalid`.

Source files
------------

// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared types and default geometry for the two-port on-chip RAM arbiter.
// The RAM is 1024 x 32 with byte lanes; the lock timeout bounds starvation.
package onchip_arb_pkg;

  localparam int ADDR_W       = 10;
  localparam int DATA_W       = 32;
  localparam int BE_W         = DATA_W / 8;
  localparam int LOCK_TIMEOUT = 16;

  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// One Avalon-MM requester port: command fields from the master and the
// waitrequest / read-response signals returned by the arbiter.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = onchip_arb_pkg::ADDR_W,
  parameter int DATA_W = onchip_arb_pkg::DATA_W,
  parameter int BE_W   = onchip_arb_pkg::BE_W
);

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              lock;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/onchip_mem_arbiter_rr_grant2.sv
// Combinational two-way round-robin grant. A masked-off requester is never
// granted; on a tie the requester that was not served last wins.
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] eligible;

  assign eligible = req & mask;

  // NOTE: grant gets a default before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port on-chip RAM between two Avalon-MM requesters with
// round-robin arbitration, an optional lock for atomic RMW, and 1-cycle reads.
module onchip_mem_arbiter #(
  parameter int ADDR_W       = onchip_arb_pkg::ADDR_W,
  parameter int DATA_W       = onchip_arb_pkg::DATA_W,
  parameter int BE_W         = onchip_arb_pkg::BE_W,
  parameter int LOCK_TIMEOUT = onchip_arb_pkg::LOCK_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  onchip_mem_arbiter_if.slave   m0,
  onchip_mem_arbiter_if.slave   m1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [BE_W-1:0]       mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  import onchip_arb_pkg::*;

  localparam logic [1:0] ST_OPEN  = 2'(OPEN);
  localparam logic [1:0] ST_LOCK0 = 2'(LOCK0);
  localparam logic [1:0] ST_LOCK1 = 2'(LOCK1);

  localparam int                IDLE_W    = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOCK_TIMEOUT - 1);

  logic [1:0]        arb_state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic              rr_last;
  logic              rd_pend;
  logic              rd_owner;

  logic [1:0]        req;
  logic [1:0]        mask;
  logic [1:0]        grant_raw;
  logic [1:0]        grant;
  logic              any_grant;
  logic              sel;

  logic [ADDR_W-1:0] cmd_address;
  logic [BE_W-1:0]   cmd_byteenable;
  logic [DATA_W-1:0] cmd_writedata;
  logic              cmd_read;
  logic              cmd_write;
  logic              cmd_lock;

  logic [ADDR_W-1:0] address_q;
  logic [BE_W-1:0]   byteenable_q;
  logic [DATA_W-1:0] writedata_q;

  // ---------------------------------------------------------------- grant
  assign req = {m1.read | m1.write, m0.read | m0.write};

  always_comb begin
    mask = 2'b11;
    case (arb_state)
      ST_LOCK0: mask = 2'b01;
      ST_LOCK1: mask = 2'b10;
      default:  mask = 2'b11;
    endcase
  end

  rr_grant2 u_rr_grant2 (
    .req     (req),
    .rr_last (rr_last),
    .mask    (mask),
    .grant   (grant_raw)
  );

  // The grant is combinational, so it must be forced off while reset is held
  // or a requesting master would see waitrequest low during reset.
  assign grant     = grant_raw & {2{reset_n}};
  assign any_grant = |grant;
  assign sel       = grant[1];

  // ---------------------------------------------------------- command mux
  always_comb begin
    cmd_address    = m0.address;
    cmd_byteenable = m0.byteenable;
    cmd_writedata  = m0.writedata;
    cmd_read       = m0.read;
    cmd_write      = m0.write;
    cmd_lock       = m0.lock;
    if (sel) begin
      cmd_address    = m1.address;
      cmd_byteenable = m1.byteenable;
      cmd_writedata  = m1.writedata;
      cmd_read       = m1.read;
      cmd_write      = m1.write;
      cmd_lock       = m1.lock;
    end
  end

  // Idle cycles keep the last command on the RAM bus to avoid needless toggling.
  assign mem_address    = any_grant ? cmd_address    : address_q;
  assign mem_byteenable = any_grant ? cmd_byteenable : byteenable_q;
  assign mem_writedata  = any_grant ? cmd_writedata  : writedata_q;
  assign mem_chipselect = any_grant;
  assign mem_write      = any_grant & cmd_write;
  assign mem_clken      = 1'b1;

  // ------------------------------------------------------ master responses
  assign m0.waitrequest   = ~grant[0];
  assign m1.waitrequest   = ~grant[1];
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rd_pend & ~rd_owner;
  assign m1.readdatavalid = rd_pend &  rd_owner;

  // ------------------------------------------------------------ lock FSM
  always_comb begin
    state_nxt = arb_state;
    idle_nxt  = idle_cnt;
    case (arb_state)
      ST_OPEN: begin
        idle_nxt = '0;
        if (any_grant && cmd_lock) begin
          state_nxt = sel ? ST_LOCK1 : ST_LOCK0;
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        // The mask guarantees that any grant here belongs to the lock owner.
        if (any_grant) begin
          idle_nxt = '0;
          if (!cmd_lock) begin
            state_nxt = ST_OPEN;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          state_nxt = ST_OPEN;
          idle_nxt  = '0;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_OPEN;
        idle_nxt  = '0;
      end
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arb_state <= ST_OPEN;
      idle_cnt  <= '0;
      rr_last   <= 1'b1;
      rd_pend   <= 1'b0;
      rd_owner  <= 1'b0;
    end else begin
      arb_state <= state_nxt;
      idle_cnt  <= idle_nxt;
      rd_pend   <= any_grant & cmd_read;
      if (any_grant) begin
        rr_last  <= sel;
        rd_owner <= sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      address_q    <= '0;
      byteenable_q <= '0;
      writedata_q  <= '0;
    end else if (any_grant) begin
      address_q    <= cmd_address;
      byteenable_q <= cmd_byteenable;
      writedata_q  <= cmd_writedata;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a behavioural model of grants, lock and RAM.
module tb_onchip_mem_arbiter;

  import onchip_arb_pkg::*;

  localparam int LT = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  onchip_mem_arbiter_if m0_if ();
  onchip_mem_arbiter_if m1_if ();

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_chipselect;
  logic              mem_write;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  onchip_mem_arbiter #(.LOCK_TIMEOUT(LT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  // Single-port RAM with registered output, as on the s1 slave.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit [31:0] ref_mem [1024];
  int        m_owner = -1;
  int        m_last  = 1;
  int        m_idle  = 0;
  int        prev_rdv = -1;
  bit [31:0] prev_data;
  int        last_g = -1;

  logic obs_wr0, obs_wr1, obs_rdv0, obs_rdv1;
  logic [31:0] obs_rd0, obs_rd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input bit rd, input bit wr, input int addr,
                       input logic [3:0] be, input logic [31:0] d, input bit lk);
    if (p == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = 10'(addr);
      m0_if.byteenable = be; m0_if.writedata = d; m0_if.lock = lk;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = 10'(addr);
      m1_if.byteenable = be; m1_if.writedata = d; m1_if.lock = lk;
    end
  endtask

  task automatic idle(input int p);
    drive(p, 0, 0, 0, 4'h0, 32'h0, 0);
  endtask

  // One clock cycle: predict, compare at the falling edge, advance the model.
  task automatic step();
    int g;
    bit r0, r1, g_rd, g_wr, g_lk;
    int g_addr;
    logic [3:0] g_be;
    logic [31:0] g_wd;
    @(negedge clk);
    obs_wr0 = m0_if.waitrequest;   obs_wr1 = m1_if.waitrequest;
    obs_rdv0 = m0_if.readdatavalid; obs_rdv1 = m1_if.readdatavalid;
    obs_rd0 = m0_if.readdata;       obs_rd1 = m1_if.readdata;
    if (!reset_n) begin
      check("rst_wait0", obs_wr0, 1);
      check("rst_wait1", obs_wr1, 1);
      check("rst_cs", mem_chipselect, 0);
      check("rst_memwr", mem_write, 0);
      check("rst_rdv0", obs_rdv0, 0);
      check("rst_rdv1", obs_rdv1, 0);
      check("rst_clken", mem_clken, 1);
      m_owner = -1; m_last = 1; m_idle = 0; prev_rdv = -1; last_g = -1;
    end else begin
      r0 = m0_if.read | m0_if.write;
      r1 = m1_if.read | m1_if.write;
      if (m_owner == 0)      g = r0 ? 0 : -1;
      else if (m_owner == 1) g = r1 ? 1 : -1;
      else if (r0 && r1)     g = (m_last == 0) ? 1 : 0;
      else if (r0)           g = 0;
      else if (r1)           g = 1;
      else                   g = -1;

      check("wait0", obs_wr0, (g != 0));
      check("wait1", obs_wr1, (g != 1));
      check("chipselect", mem_chipselect, (g >= 0));
      check("rdv0", obs_rdv0, (prev_rdv == 0));
      check("rdv1", obs_rdv1, (prev_rdv == 1));
      if (prev_rdv == 0) check("rdata0", obs_rd0, prev_data);
      if (prev_rdv == 1) check("rdata1", obs_rd1, prev_data);

      prev_rdv = -1;
      if (g >= 0) begin
        g_rd   = (g == 0) ? m0_if.read : m1_if.read;
        g_wr   = (g == 0) ? m0_if.write : m1_if.write;
        g_lk   = (g == 0) ? m0_if.lock : m1_if.lock;
        g_addr = (g == 0) ? int'(m0_if.address) : int'(m1_if.address);
        g_be   = (g == 0) ? m0_if.byteenable : m1_if.byteenable;
        g_wd   = (g == 0) ? m0_if.writedata : m1_if.writedata;
        check("mem_addr", 32'(mem_address), 32'(g_addr));
        check("mem_write", mem_write, g_wr);
        if (g_wr) begin
          check("mem_be", 32'(mem_byteenable), 32'(g_be));
          check("mem_wdata", mem_writedata, g_wd);
          for (int b = 0; b < 4; b++)
            if (g_be[b]) ref_mem[g_addr][8*b +: 8] = g_wd[8*b +: 8];
        end
        if (g_rd) begin
          prev_rdv  = g;
          prev_data = ref_mem[g_addr];
        end
        m_last = g;
      end else begin
        g_lk = 0;
        check("mem_write_idle", mem_write, 0);
      end

      // Lock bookkeeping: owner activity clears the idle count; LT idle cycles release.
      if (m_owner >= 0) begin
        if (g == m_owner) begin
          m_idle = 0;
          if (!g_lk) m_owner = -1;
        end else if (m_idle == LT - 1) begin
          m_owner = -1;
          m_idle  = 0;
        end else begin
          m_idle++;
        end
      end else if (g >= 0 && g_lk) begin
        m_owner = g;
        m_idle  = 0;
      end
      last_g = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int p, input bit rd, input bit wr, input int addr,
                      input logic [3:0] be, input logic [31:0] d, input bit lk);
    drive(p, rd, wr, addr, be, d, lk);
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_g == p) break;
    end
    check("xfer_grant", 32'(last_g), 32'(p));
    idle(p);
  endtask

  initial begin
    int i0, i1, pg, alt_bad, n0, n1, n;
    reset_n = 1'b0;
    drive(0, 1, 0, 'h005, 4'hF, 32'h0, 0);
    drive(1, 1, 0, 'h006, 4'hF, 32'h0, 0);

    // Reset held with both requesting, then port 0 wins the first tie.
    step();
    step();
    reset_n = 1'b1;
    step();
    check("first_grant", 32'(last_g), 32'd0);
    idle(0); idle(1);
    step();

    // Seed the RAM locations the directed reads use.
    for (int a = 0; a < 4; a++) xfer(0, 0, 1, 'h010 + a, 4'hF, 32'hC0DE_0010 + 32'(a), 0);
    xfer(0, 0, 1, 'h020, 4'hF, 32'h0000_0020, 0);

    // Single write then read on port 0.
    xfer(0, 0, 1, 'h005, 4'hF, 32'hDEADBEEF, 0);
    xfer(0, 1, 0, 'h005, 4'hF, 32'h0, 0);
    check("single_accept", obs_wr0, 0);
    step();
    check("single_rdv", obs_rdv0, 1);
    check("single_rdata", obs_rd0, 32'hDEADBEEF);

    // Contention: 4 back-to-back reads per port.
    i0 = 0; i1 = 0; pg = -1; alt_bad = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 20 && (i0 < 4 || i1 < 4); c++) begin
      if (i0 < 4) drive(0, 1, 0, 'h010 + i0, 4'hF, 32'h0, 0); else idle(0);
      if (i1 < 4) drive(1, 1, 0, 'h010 + i1, 4'hF, 32'h0, 0); else idle(1);
      step();
      n0 += int'(obs_rdv0); n1 += int'(obs_rdv1);
      if (last_g < 0 || last_g == pg) alt_bad++;
      pg = last_g;
      if (last_g == 0) i0++;
      if (last_g == 1) i1++;
    end
    idle(0); idle(1);
    step();
    n0 += int'(obs_rdv0); n1 += int'(obs_rdv1);
    check("contend_alternate", 32'(alt_bad), 32'd0);
    check("contend_rdv0_cnt", 32'(n0), 32'd4);
    check("contend_rdv1_cnt", 32'(n1), 32'd4);

    // Byte lanes at the top address.
    xfer(1, 0, 1, 'h3FF, 4'hF, 32'h11223344, 0);
    xfer(1, 0, 1, 'h3FF, 4'h8, 32'hAA000000, 0);
    xfer(1, 1, 0, 'h3FF, 4'hF, 32'h0, 0);
    step();
    check("bytelane_rdata", obs_rd1, 32'hAA223344);

    // Locked read-modify-write by port 1 while port 0 keeps requesting.
    xfer(0, 0, 1, 'h030, 4'hF, 32'h1234_5678, 0);
    drive(0, 1, 0, 'h005, 4'hF, 32'h0, 0);
    drive(1, 1, 0, 'h020, 4'hF, 32'h0, 1);
    step();
    check("lock_first", 32'(last_g), 32'd1);
    idle(1);
    step();
    check("lock_hold_a", obs_wr0, 1);
    step();
    check("lock_hold_b", obs_wr0, 1);
    drive(1, 0, 1, 'h020, 4'hF, 32'h0000_0021, 0);
    step();
    check("lock_unlock_wr", 32'(last_g), 32'd1);
    check("lock_hold_c", obs_wr0, 1);
    idle(1);
    step();
    check("lock_release", 32'(last_g), 32'd0);

    // Lock timeout: port 1 locks, goes idle, port 0 waits LT+1 cycles.
    drive(1, 1, 0, 'h020, 4'hF, 32'h0, 1);
    step();
    check("timeout_lock", 32'(last_g), 32'd1);
    idle(1);
    n = 0;
    for (int c = 0; c < LT + 10; c++) begin
      step();
      n++;
      if (last_g == 0) break;
    end
    check("timeout_cycles", 32'(n), 32'(LT + 1));
    idle(0);
    step();

    // Random traffic on a small, pre-seeded window.
    for (int a = 0; a < 16; a++) xfer(0, 0, 1, 'h040 + a, 4'hF, $urandom, 0);
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        int op;
        op = int'($urandom_range(0, 3));
        drive(p, (op == 1 || op == 3), (op == 2), 'h040 + int'($urandom_range(0, 15)),
              4'($urandom_range(1, 15)), $urandom, ($urandom_range(0, 7) == 0));
      end
      step();
    end
    idle(0); idle(1);
    for (int c = 0; c < LT + 2; c++) step();

    // Reset mid-read drops the pending response.
    drive(0, 1, 0, 'h005, 4'hF, 32'h0, 0);
    step();
    check("midrst_grant", 32'(last_g), 32'd0);
    idle(0);
    reset_n = 1'b0;
    step();
    check("midrst_rdv_drop", obs_rdv0, 0);
    reset_n = 1'b1;
    step();
    check("post_rst_rdv", obs_rdv0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
